// File: rtl/audio_pkg.sv
// Shared types and constants for the flash-to-averager audio path.
package audio_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT
    } fetch_state_t;

    localparam int FLASH_DATA_W = 32;
    localparam int SAMPLE_W     = 8;

    localparam logic [SAMPLE_W-1:0] SILENT_SAMPLE = 8'h00;

    // Each 16-bit half carries one sample in its upper byte: {second, first}.
    function automatic logic [2*SAMPLE_W-1:0] sample_pair(input logic [FLASH_DATA_W-1:0] word);
        return {word[31:24], word[15:8]};
    endfunction

endpackage

// File: rtl/flash_word_fetcher.sv
// Avalon-MM read master holding one prefetched sample pair; a drain flag
// swallows the word of a read that was already issued when a restart hit.
module flash_word_fetcher
    import audio_pkg::*;
#(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    restart,
    input  logic                    reverse,
    input  logic                    word_ack,
    output logic                    word_valid,
    output logic [2*SAMPLE_W-1:0]   word_data,
    output logic                    flash_read,
    output logic [ADDR_W-1:0]       flash_address,
    input  logic                    flash_waitrequest,
    input  logic [FLASH_DATA_W-1:0] flash_readdata,
    input  logic                    flash_readdatavalid
);

    fetch_state_t            state_reg, state_next;
    logic [ADDR_W-1:0]       addr_reg;
    logic                    drain_reg;
    logic                    slot_valid_reg;
    logic [2*SAMPLE_W-1:0]   slot_data_reg;
    logic [ADDR_W-1:0]       base_addr;
    logic [ADDR_W-1:0]       addr_next;

    assign base_addr = reverse ? END_ADDR : START_ADDR;

    always_comb begin
        addr_next = addr_reg + ADDR_W'(1);
        if (reverse)
            addr_next = (addr_reg == START_ADDR) ? END_ADDR : addr_reg - ADDR_W'(1);
        else if (addr_reg == END_ADDR)
            addr_next = START_ADDR;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            F_IDLE: if (!slot_valid_reg)      state_next = F_REQ;
            F_REQ:  if (!flash_waitrequest)   state_next = F_WAIT;
            F_WAIT: if (flash_readdatavalid)  state_next = F_IDLE;
            default:                          state_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= F_IDLE;
            addr_reg       <= START_ADDR;
            drain_reg      <= 1'b0;
            slot_valid_reg <= 1'b0;
            slot_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (word_ack)
                slot_valid_reg <= 1'b0;
            case (state_reg)
                F_IDLE: begin
                    if (restart)
                        addr_reg <= base_addr;
                end
                // The address is frozen while the request is pending; rewind once accepted.
                F_REQ: begin
                    if (!flash_waitrequest) begin
                        if (restart || drain_reg) begin
                            addr_reg  <= base_addr;
                            drain_reg <= 1'b1;
                        end
                    end else if (restart) begin
                        drain_reg <= 1'b1;
                    end
                end
                F_WAIT: begin
                    if (flash_readdatavalid) begin
                        drain_reg <= 1'b0;
                        if (restart) begin
                            addr_reg <= base_addr;
                        end else if (!drain_reg) begin
                            slot_valid_reg <= 1'b1;
                            slot_data_reg  <= sample_pair(flash_readdata);
                            addr_reg       <= addr_next;
                        end
                    end else if (restart) begin
                        addr_reg  <= base_addr;
                        drain_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (restart)
                slot_valid_reg <= 1'b0;
        end
    end

    assign flash_read    = (state_reg == F_REQ);
    assign flash_address = addr_reg;
    assign word_valid    = slot_valid_reg;
    assign word_data     = slot_data_reg;

endmodule

// File: rtl/flash_sample_reader.sv
// Plays flash-resident 8-bit audio at the sample tick rate into the averager.
// Optional REVERSE_PLAY_EN adds a direction input for backwards playback.
module flash_sample_reader
    import audio_pkg::*;
#(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_tick,
    input  logic                    play_en,
    input  logic                    restart,
`ifdef REVERSE_PLAY_EN
    input  logic                    direction,
`endif
    output logic                    flash_read,
    output logic [ADDR_W-1:0]       flash_address,
    input  logic                    flash_waitrequest,
    input  logic [FLASH_DATA_W-1:0] flash_readdata,
    input  logic                    flash_readdatavalid,
    output logic [SAMPLE_W-1:0]     audio_out,
    output logic                    sample_valid,
    output logic                    silent_flag,
    output logic                    underrun
);

    logic                  restart_eff;
    logic                  reverse_live;
    logic                  reverse_play;
    logic                  word_valid;
    logic [2*SAMPLE_W-1:0] word_data;
    logic                  word_ack;

`ifdef REVERSE_PLAY_EN
    logic dir_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dir_reg <= 1'b0;
        else
            dir_reg <= direction;
    end

    // A direction flip rewinds to the new end of the clip.
    assign restart_eff  = restart | (direction != dir_reg);
    assign reverse_live = direction;
    assign reverse_play = dir_reg;
`else
    assign restart_eff  = restart;
    assign reverse_live = 1'b0;
    assign reverse_play = 1'b0;
`endif

    flash_word_fetcher #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_fetcher (
        .clk                 (clk),
        .reset_n             (reset_n),
        .restart             (restart_eff),
        .reverse             (reverse_live),
        .word_ack            (word_ack),
        .word_valid          (word_valid),
        .word_data           (word_data),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid)
    );

    logic [2*SAMPLE_W-1:0] cur_pair_reg;
    logic                  cur_valid_reg;
    logic                  half_reg;
    logic [SAMPLE_W-1:0]   audio_reg;
    logic                  sample_valid_reg;
    logic                  silent_reg;
    logic                  underrun_reg;
    logic                  play_now;
    logic [SAMPLE_W-1:0]   play_byte;

    assign play_now  = sample_tick && play_en && cur_valid_reg && !restart_eff;
    assign play_byte = (half_reg ^ reverse_play) ? cur_pair_reg[15:8] : cur_pair_reg[7:0];
    // The prefetch slot refills cur when it is empty or its last half is being played.
    assign word_ack  = word_valid && !restart_eff && (!cur_valid_reg || (play_now && half_reg));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_pair_reg     <= '0;
            cur_valid_reg    <= 1'b0;
            half_reg         <= 1'b0;
            audio_reg        <= SILENT_SAMPLE;
            sample_valid_reg <= 1'b0;
            silent_reg       <= 1'b1;
            underrun_reg     <= 1'b0;
        end else begin
            sample_valid_reg <= sample_tick;
            underrun_reg     <= 1'b0;
            if (restart_eff) begin
                cur_valid_reg <= 1'b0;
                half_reg      <= 1'b0;
            end else begin
                if (!cur_valid_reg && word_valid) begin
                    cur_pair_reg  <= word_data;
                    cur_valid_reg <= 1'b1;
                end
                if (play_now) begin
                    half_reg <= ~half_reg;
                    if (half_reg) begin
                        if (word_valid)
                            cur_pair_reg <= word_data;
                        cur_valid_reg <= word_valid;
                    end
                end
            end
            if (sample_tick) begin
                if (play_now) begin
                    audio_reg  <= play_byte;
                    silent_reg <= 1'b0;
                end else begin
                    audio_reg    <= SILENT_SAMPLE;
                    silent_reg   <= 1'b1;
                    underrun_reg <= play_en && !restart_eff;
                end
            end
        end
    end

    assign audio_out    = audio_reg;
    assign sample_valid = sample_valid_reg;
    assign silent_flag  = silent_reg;
    assign underrun     = underrun_reg;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Scoreboard bench for flash_sample_reader with a 4-word clip and a flash model.
module tb_flash_sample_reader;

    localparam int K_PLAY = 0, K_SILENT = 1, K_UNDER = 2, K_VAL = 3;

    typedef struct {
        logic [7:0] audio;
        logic       silent;
        logic       under;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        play_en = 1'b0;
    logic        restart = 1'b0;
    logic        direction = 1'b0;
    logic        flash_read;
    logic [22:0] flash_address;
    logic        flash_waitrequest = 1'b0;
    logic [31:0] flash_readdata = '0;
    logic        flash_readdatavalid = 1'b0;
    logic [7:0]  audio_out;
    logic        sample_valid;
    logic        silent_flag;
    logic        underrun;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    int   stream_idx = 0;
    int   lat = 3;
    int   rd_log[$];
    int   pend_cnt = 0;
    logic [22:0] pend_addr = '0;
    logic tick_at_edge = 1'b0;
    int   n_samples = 0;

    always #5 clk = ~clk;

    flash_sample_reader #(
        .ADDR_W     (23),
        .START_ADDR (23'h000000),
        .END_ADDR   (23'h000003)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .sample_tick         (sample_tick),
        .play_en             (play_en),
        .restart             (restart),
`ifdef REVERSE_PLAY_EN
        .direction           (direction),
`endif
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .audio_out           (audio_out),
        .sample_valid        (sample_valid),
        .silent_flag         (silent_flag),
        .underrun            (underrun)
    );

    function automatic logic [31:0] word_at(input int a);
        case (a)
            0:       return 32'hA1B2_C3D4;
            1:       return 32'h5566_7788;
            2:       return 32'h99AA_BBCC;
            3:       return 32'h1122_3344;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [7:0] stream_byte(input int k);
        logic [31:0] w;
        w = word_at((k / 2) % 4);
        return (k % 2 == 1) ? w[31:24] : w[15:8];
    endfunction

    // Flash model: accepts a read when waitrequest is low, answers lat cycles later.
    always @(negedge clk) begin
        flash_readdatavalid = 1'b0;
        if (!reset_n) begin
            pend_cnt = 0;
        end else begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    flash_readdatavalid = 1'b1;
                    flash_readdata = word_at(int'(pend_addr));
                end
            end
            if (flash_read && !flash_waitrequest) begin
                pend_cnt  = lat;
                pend_addr = flash_address;
                rd_log.push_back(int'(flash_address));
            end
        end
    end

    always @(posedge clk) tick_at_edge <= sample_tick;

    // Output monitor: strobe cadence plus scoreboard pop on every sample_valid.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (tick_at_edge || sample_valid)) begin
            total++;
            if (sample_valid !== tick_at_edge) begin
                bad++;
                $display("FAIL cadence: sample_valid=%b required=%b at %0t", sample_valid, tick_at_edge, $time);
            end
            if (sample_valid) begin
                total++;
                n_samples++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_sample: audio=%h with empty scoreboard", audio_out);
                end else begin
                    e = sb.pop_front();
                    $display("sample %0d: audio=%h silent=%b underrun=%b (exp %h %b %b)",
                             n_samples, audio_out, silent_flag, underrun, e.audio, e.silent, e.under);
                    if ({audio_out, silent_flag, underrun} !== {e.audio, e.silent, e.under}) begin
                        bad++;
                        $display("FAIL sample: got audio=%h silent=%b underrun=%b required audio=%h silent=%b underrun=%b",
                                 audio_out, silent_flag, underrun, e.audio, e.silent, e.under);
                    end
                end
            end
        end
    end

    task automatic pulse_tick(input int kind, input logic [7:0] val);
        exp_t e;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        e.audio = 8'h00; e.silent = 1'b1; e.under = 1'b0;
        case (kind)
            K_PLAY:  begin e.audio = stream_byte(stream_idx); e.silent = 1'b0; stream_idx++; end
            K_UNDER: e.under = 1'b1;
            K_VAL:   begin e.audio = val; e.silent = 1'b0; end
            default: ;
        endcase
        sb.push_back(e);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        repeat (18) @(posedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (flash_read !== 1'b0) begin bad++; $display("FAIL reset_read: got %b required 0", flash_read); end
        total++; if (flash_address !== 23'h0) begin bad++; $display("FAIL reset_addr: got %h required 0", flash_address); end
        total++; if (audio_out !== 8'h00) begin bad++; $display("FAIL reset_audio: got %h required 00", audio_out); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", sample_valid); end
        total++; if (silent_flag !== 1'b1) begin bad++; $display("FAIL reset_silent: got %b required 1", silent_flag); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b required 0", underrun); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        play_en = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_play_and_wrap;
        int exp_addr [6] = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 12; i++) pulse_tick(K_PLAY, 8'h00);
        total++;
        if (rd_log.size() < 6) begin
            bad++;
            $display("FAIL wrap_count: got %0d reads required >= 6", rd_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (rd_log[i] != exp_addr[i]) begin
                    bad++;
                    $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, rd_log[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_pause;
        #1 play_en = 1'b0;
        for (int i = 0; i < 10; i++) pulse_tick(K_SILENT, 8'h00);
        #1 play_en = 1'b1;
        for (int i = 0; i < 4; i++) pulse_tick(K_PLAY, 8'h00);
    endtask

    task automatic test_underrun;
        int avail;
        repeat (10) @(posedge clk);
        #1 flash_waitrequest = 1'b1;
        avail = 4 - (stream_idx % 2);
        for (int i = 0; i < 10; i++) pulse_tick((i < avail) ? K_PLAY : K_UNDER, 8'h00);
        #1 flash_waitrequest = 1'b0;
        repeat (10) @(posedge clk);
        for (int i = 0; i < 4; i++) pulse_tick(K_PLAY, 8'h00);
    endtask

    task automatic test_restart_in_wait;
        bit accepted = 0;
        int nreads;
        exp_t e;
        lat = 12;
        if (stream_idx % 2 == 0) pulse_tick(K_PLAY, 8'h00);
        @(posedge clk); #1;
        sample_tick = 1'b1;
        e.audio = stream_byte(stream_idx); e.silent = 1'b0; e.under = 1'b0;
        stream_idx++;
        sb.push_back(e);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        for (int n = 0; n < 20 && !accepted; n++) begin
            @(negedge clk);
            if (flash_read && !flash_waitrequest) accepted = 1;
        end
        total++;
        if (!accepted) begin
            bad++;
            $display("FAIL restart_accept_timeout: no read accepted within 20 cycles");
        end
        @(posedge clk); #1;
        restart = 1'b1;
        nreads = rd_log.size();
        stream_idx = 0;
        @(posedge clk); #1;
        restart = 1'b0;
        repeat (60) @(posedge clk);
        lat = 3;
        total++;
        if (rd_log.size() <= nreads) begin
            bad++;
            $display("FAIL restart_read_count: got %0d reads required > %0d", rd_log.size(), nreads);
        end else begin
            total++;
            if (rd_log[nreads] != 0) begin
                bad++;
                $display("FAIL restart_addr: got %0d required 0", rd_log[nreads]);
            end
        end
        for (int i = 0; i < 3; i++) pulse_tick(K_PLAY, 8'h00);
    endtask

    task automatic test_restart_with_tick;
        exp_t e;
        @(posedge clk); #1;
        restart = 1'b1;
        sample_tick = 1'b1;
        e.audio = 8'h00; e.silent = 1'b1; e.under = 1'b0;
        sb.push_back(e);
        stream_idx = 0;
        @(posedge clk); #1;
        restart = 1'b0;
        sample_tick = 1'b0;
        repeat (40) @(posedge clk);
        for (int i = 0; i < 3; i++) pulse_tick(K_PLAY, 8'h00);
    endtask

    task automatic test_reset_mid_read;
        bit seen = 0;
        #1 flash_waitrequest = 1'b1;
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (flash_read) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midread_timeout: flash_read never asserted");
        end
        #2 reset_n = 1'b0;
        #1;
        total++; if (flash_read !== 1'b0) begin bad++; $display("FAIL async_read: got %b required 0", flash_read); end
        total++; if (flash_address !== 23'h0) begin bad++; $display("FAIL async_addr: got %h required 0", flash_address); end
        total++; if (silent_flag !== 1'b1) begin bad++; $display("FAIL async_silent: got %b required 1", silent_flag); end
        total++; if (audio_out !== 8'h00) begin bad++; $display("FAIL async_audio: got %h required 00", audio_out); end
        flash_waitrequest = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        stream_idx = 0;
        repeat (20) @(posedge clk);
        for (int i = 0; i < 2; i++) pulse_tick(K_PLAY, 8'h00);
    endtask

`ifdef REVERSE_PLAY_EN
    task automatic test_reverse;
        int nreads;
        #1 direction = 1'b1;
        nreads = rd_log.size();
        repeat (40) @(posedge clk);
        pulse_tick(K_VAL, 8'h11);
        pulse_tick(K_VAL, 8'h33);
        total++;
        if (rd_log.size() < nreads + 2) begin
            bad++;
            $display("FAIL reverse_count: got %0d reads required >= %0d", rd_log.size(), nreads + 2);
        end else begin
            total++;
            if (rd_log[nreads] != 3 || rd_log[nreads + 1] != 2) begin
                bad++;
                $display("FAIL reverse_addr: got %0d,%0d required 3,2", rd_log[nreads], rd_log[nreads + 1]);
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_play_and_wrap();
        test_pause();
        test_underrun();
        test_restart_in_wait();
        test_restart_with_tick();
        test_reset_mid_read();
`ifdef REVERSE_PLAY_EN
        test_reverse();
`endif
        repeat (30) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
